record_manager_fsm: RTL



---
 rtl/record_manager_fsm.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/record_manager_fsm.sv
// ---------------------------------------------------------------------------
// record_manager_fsm
//   Collects REC_LEN words from an RS receiver into a record buffer, then
//   writes them one word at a time to a flash controller, waiting for the
//   flash acknowledge after each write. Repeats for NUM_REC records, then
//   halts in STOP. Generates linear flash addresses from BASE_ADDR and
//   flags words that arrive when the FSM is not ready to take them.
//
//   Optional feature macro: FL_TIMEOUT_EN
//     defined   : a per-word ack timeout of TIMEOUT_CYC cycles leads to ERROR
//     undefined : WAITING_FL waits indefinitely, ERR is tied low
//
// Ports:
//   CLK_50MHZ  in   1       system clock
//   RST        in   1       asynchronous active-high reset
//   RS_DONE    in   1       one-cycle strobe, RS_DATA valid
//   RS_DATA    in   DATA_W  received word
//   FL_STATUS  in   1       flash write acknowledge (sampled each cycle)
//   FL_WE      out  1       one-cycle flash write strobe
//   FL_ADDR    out  ADDR_W  flash write address, valid with FL_WE
//   FL_DATA    out  DATA_W  flash write data, valid with FL_WE
//   STATE      out  3       current state encoding
//   DONE       out  1       high while in STOP
//   OVERRUN    out  1       sticky: RS_DONE seen outside WAITING_RS
//   ERR        out  1       sticky: flash ack timeout
// ---------------------------------------------------------------------------
module record_manager_fsm #(
  parameter int DATA_W      = 8,
  parameter int REC_LEN     = 4,
  parameter int NUM_REC     = 16,
  parameter int ADDR_W      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              RS_DONE,
  input  logic [DATA_W-1:0] RS_DATA,
  input  logic              FL_STATUS,
  output logic              FL_WE,
  output logic [ADDR_W-1:0] FL_ADDR,
  output logic [DATA_W-1:0] FL_DATA,
  output logic [2:0]        STATE,
  output logic              DONE,
  output logic              OVERRUN,
  output logic              ERR
);

  localparam int IDX_W = (REC_LEN > 1) ? $clog2(REC_LEN) : 1;
  localparam int REC_W = (NUM_REC > 1) ? $clog2(NUM_REC) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(REC_LEN - 1);
  localparam logic [REC_W-1:0]  LAST_REC = REC_W'(NUM_REC - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RS  = 3'd1,
    S_READ_RS  = 3'd2,
    S_WRITE_FL = 3'd3,
    S_WAIT_FL  = 3'd4,
    S_STOP     = 3'd5,
    S_ERROR    = 3'd6
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    rd_idx_q;
  logic [IDX_W-1:0]    wr_idx_q;
  logic [REC_W-1:0]    rec_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                fl_we_q;
  logic [DATA_W-1:0]   fl_data_q;
  logic                done_q;
  logic                overrun_q;
  logic [DATA_W-1:0]   rec_buf [REC_LEN];

  logic                buf_we_s;
  logic                ack_s;

`ifdef FL_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic                err_q;
`endif

  // A word is accepted only while waiting for one.
  assign buf_we_s = (state_q == S_WAIT_RS) && RS_DONE;
  // The ack is ignored on the write-strobe cycle itself.
  assign ack_s    = FL_STATUS && !fl_we_q;

  // Record buffer: plain storage, contents are don't-care after reset.
  always_ff @(posedge CLK_50MHZ) begin
    if (buf_we_s) begin
      rec_buf[rd_idx_q] <= RS_DATA;
    end
  end

  // Main controller: state, indices, address and registered outputs.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
      rec_cnt_q <= '0;
      addr_q    <= BASE;
      fl_we_q   <= 1'b0;
      fl_data_q <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef FL_TIMEOUT_EN
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      fl_we_q <= 1'b0;
      // Words arriving while busy are dropped and flagged.
      if (RS_DONE && (state_q != S_WAIT_RS)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          state_q <= S_WAIT_RS;
        end
        S_WAIT_RS: begin
          if (RS_DONE) begin
            state_q <= S_READ_RS;
          end
        end
        S_READ_RS: begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            state_q  <= S_WRITE_FL;
          end else begin
            rd_idx_q <= rd_idx_q + 1'b1;
            state_q  <= S_WAIT_RS;
          end
        end
        S_WRITE_FL: begin
          fl_we_q   <= 1'b1;
          fl_data_q <= rec_buf[wr_idx_q];
`ifdef FL_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
          state_q   <= S_WAIT_FL;
        end
        S_WAIT_FL: begin
          if (ack_s) begin
            addr_q <= addr_q + 1'b1;
            if (wr_idx_q == LAST_IDX) begin
              if (rec_cnt_q == LAST_REC) begin
                done_q  <= 1'b1;
                state_q <= S_STOP;
              end else begin
                rec_cnt_q <= rec_cnt_q + 1'b1;
                state_q   <= S_WAIT_RS;
              end
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
              state_q  <= S_WRITE_FL;
            end
          end
`ifdef FL_TIMEOUT_EN
          // An ack on the final allowed cycle takes priority over the timeout.
          else if (tmo_cnt_q == LAST_TMO) begin
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        S_STOP: begin
          done_q  <= 1'b1;
          state_q <= S_STOP;
        end
        S_ERROR: begin
          state_q <= S_ERROR;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign FL_WE   = fl_we_q;
  assign FL_ADDR = addr_q;
  assign FL_DATA = fl_data_q;
  assign STATE   = state_q;
  assign DONE    = done_q;
  assign OVERRUN = overrun_q;
`ifdef FL_TIMEOUT_EN
  assign ERR     = err_q;
`else
  assign ERR     = 1'b0;
`endif

endmodule
